pcs_sync_param: RTL

- Parametrised successor to the PCS receive synchronization block. Sits after the 8b/10b encoder output (loopback) or the deserializer, and feeds the receive state machine.
- Detects comma alignment on the 10-bit code-group stream, tracks running disparity and code-group validity, and runs a generalised acquire/lose-sync state machine.
- Acquire and loss thresholds are parameters instead of the fixed 3/4 counts.
- Outputs the registered code group (SUDI), the even/odd marker, and sync status.

---
 rtl/pcs_sync_param.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/pcs_sync_param.sv
// PCS receive synchronization with parametrised acquire/lose thresholds.
// Define SYNC_STATS_EN to add the saturating los_count / bad_cg_count statistics.
module pcs_sync_param #(
  parameter int COMMAS_TO_SYNC   = 3,
  parameter int BAD_CGS_LOSE     = 4,
  parameter int GOOD_CGS_RECOVER = 4,
  parameter int STAT_W           = 16
) (
  input  logic              GTX_CLK,
  input  logic              mr_main_reset,
  input  logic [9:0]        rx_code_group,
  output logic [9:0]        SUDI,
  output logic              rx_even,
  output logic              sync_status,
  output logic              cg_bad
`ifdef SYNC_STATS_EN
  ,
  output logic [STAT_W-1:0] los_count,
  output logic [STAT_W-1:0] bad_cg_count
`endif
);

  if (COMMAS_TO_SYNC < 2 || COMMAS_TO_SYNC > 15 ||
      BAD_CGS_LOSE < 1 || BAD_CGS_LOSE > 15 ||
      GOOD_CGS_RECOVER < 1 || GOOD_CGS_RECOVER > 15 ||
      STAT_W < 1) begin : g_param_check
    $error("pcs_sync_param: parameter out of range");
  end

  localparam logic [3:0] COMMA_TGT = 4'(COMMAS_TO_SYNC);
  localparam logic [3:0] BAD_TGT   = 4'(BAD_CGS_LOSE);
  localparam logic [3:0] GOOD_TGT  = 4'(GOOD_CGS_RECOVER);

  typedef enum logic [1:0] {
    LOSS_OF_SYNC  = 2'd0,
    ACQUIRE_SYNC  = 2'd1,
    SYNC_ACQUIRED = 2'd2
  } state_t;

  function automatic logic [3:0] ones10(input logic [9:0] v);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 10; i++) s = s + {3'b000, v[i]};
    return s;
  endfunction

  state_t     state, state_nxt;
  logic       rd, rd_nxt;               // 1 = positive running disparity
  logic [3:0] comma_cnt, comma_cnt_nxt;
  logic [3:0] bad_cnt, bad_cnt_nxt;
  logic [3:0] good_cnt, good_cnt_nxt;
  logic       even_nxt;
  logic       sync_nxt;

  logic [3:0] ones;
  logic       comma;
  logic       valid_any;
  logic       valid_rd;
  logic       invalid;
  logic       odd_pos;
  logic       cgbad;

  assign ones      = ones10(rx_code_group);
  assign comma     = (rx_code_group[9:3] == 7'b0011111) ||
                     (rx_code_group[9:3] == 7'b1100000);
  assign valid_any = (ones == 4'd4) || (ones == 4'd5) || (ones == 4'd6);
  assign valid_rd  = (ones == 4'd5) || ((ones == 4'd6) && !rd) || ((ones == 4'd4) && rd);
  assign invalid   = (state == LOSS_OF_SYNC) ? !valid_any : !valid_rd;
  assign odd_pos   = rx_even;

  // Alignment is unknown before the first comma, so position only matters once acquiring.
  assign cgbad     = invalid || ((state != LOSS_OF_SYNC) && comma && odd_pos);

  always_comb begin
    state_nxt     = state;
    comma_cnt_nxt = comma_cnt;
    bad_cnt_nxt   = bad_cnt;
    good_cnt_nxt  = good_cnt;
    rd_nxt        = rd;
    even_nxt      = (comma && !cgbad) ? 1'b1 : !rx_even;

    // A valid 6-ones group leaves positive disparity, a valid 4-ones group negative.
    if (!invalid) begin
      if (ones == 4'd6)      rd_nxt = 1'b1;
      else if (ones == 4'd4) rd_nxt = 1'b0;
    end

    case (state)
      LOSS_OF_SYNC: begin
        if (comma && !cgbad) begin
          state_nxt     = ACQUIRE_SYNC;
          comma_cnt_nxt = 4'd1;
        end
      end
      ACQUIRE_SYNC: begin
        if (cgbad) begin
          state_nxt     = LOSS_OF_SYNC;
          comma_cnt_nxt = 4'd0;
        end else if (comma) begin
          comma_cnt_nxt = comma_cnt + 4'd1;
          if (comma_cnt + 4'd1 == COMMA_TGT) begin
            state_nxt    = SYNC_ACQUIRED;
            bad_cnt_nxt  = 4'd0;
            good_cnt_nxt = 4'd0;
          end
        end
      end
      SYNC_ACQUIRED: begin
        if (cgbad) begin
          good_cnt_nxt = 4'd0;
          if (bad_cnt + 4'd1 == BAD_TGT) begin
            state_nxt     = LOSS_OF_SYNC;
            bad_cnt_nxt   = 4'd0;
            comma_cnt_nxt = 4'd0;
          end else begin
            bad_cnt_nxt = bad_cnt + 4'd1;
          end
        end else if (bad_cnt != 4'd0) begin
          if (good_cnt + 4'd1 == GOOD_TGT) begin
            bad_cnt_nxt  = bad_cnt - 4'd1;
            good_cnt_nxt = 4'd0;
          end else begin
            good_cnt_nxt = good_cnt + 4'd1;
          end
        end else begin
          good_cnt_nxt = 4'd0;
        end
      end
      default: begin
        state_nxt     = LOSS_OF_SYNC;
        comma_cnt_nxt = 4'd0;
        bad_cnt_nxt   = 4'd0;
        good_cnt_nxt  = 4'd0;
      end
    endcase

    sync_nxt = (state_nxt == SYNC_ACQUIRED);
  end

  always_ff @(posedge GTX_CLK) begin
    if (!mr_main_reset) begin
      state       <= LOSS_OF_SYNC;
      rd          <= 1'b0;
      comma_cnt   <= 4'd0;
      bad_cnt     <= 4'd0;
      good_cnt    <= 4'd0;
      SUDI        <= 10'd0;
      rx_even     <= 1'b0;
      sync_status <= 1'b0;
      cg_bad      <= 1'b0;
    end else begin
      state       <= state_nxt;
      rd          <= rd_nxt;
      comma_cnt   <= comma_cnt_nxt;
      bad_cnt     <= bad_cnt_nxt;
      good_cnt    <= good_cnt_nxt;
      SUDI        <= rx_code_group;
      rx_even     <= even_nxt;
      sync_status <= sync_nxt;
      cg_bad      <= cgbad;
    end
  end

`ifdef SYNC_STATS_EN
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic los_inc;
  logic bad_inc;

  assign los_inc = (state == SYNC_ACQUIRED) && (state_nxt == LOSS_OF_SYNC);
  assign bad_inc = (state == SYNC_ACQUIRED) && cgbad;

  always_ff @(posedge GTX_CLK) begin
    if (!mr_main_reset) begin
      los_count    <= '0;
      bad_cg_count <= '0;
    end else begin
      if (los_inc) los_count    <= sat_inc(los_count);
      if (bad_inc) bad_cg_count <= sat_inc(bad_cg_count);
    end
  end
`endif

endmodule
